// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial 8-bit subtractor.
// The SUB_OVERFLOW_EN macro is consumed by tt_um_serial_subtractor.
package serial_sub_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // uio_in control bits
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;

    // uio_out status bits
    localparam int BUSY   = 7;
    localparam int DONE   = 6;
    localparam int BORROW = 5;
    localparam int OVF    = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       UIO_OE   = 8'hF0;

endpackage

// File: rtl/full_sub1.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module full_sub1 (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit subtractor, LSB first, one bit per cycle.
// Define SUB_OVERFLOW_EN to add the signed-overflow flag on uio_out[4].
module tt_um_serial_subtractor
    import serial_sub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bin_q, bin_d;
    logic [WIDTH-1:0]   uo_q, uo_d;
    logic               borrow_q, borrow_d;
    logic               ovf_bit;
    logic               bit_d, bit_bout;
    logic [WIDTH-1:0]   diff_full;

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};

    full_sub1 u_fs (
        .x_i    (sa_q[0]),
        .y_i    (sb_q[0]),
        .bin_i  (bin_q),
        .d_o    (bit_d),
        .bout_o (bit_bout)
    );

    // Earlier bits sit in res_q LSB-aligned once the last bit arrives.
    assign diff_full = {bit_d, res_q};

`ifdef SUB_OVERFLOW_EN
    logic ovf_q, ovf_d;
    assign ovf_bit = ovf_q;
`else
    assign ovf_bit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        uo_d     = uo_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (uio_in[START]) begin
                        sa_d    = a_q;
                        sb_d    = b_q;
                        res_d   = '0;
                        cnt_d   = '0;
                        bin_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        if (uio_in[LOAD_A]) a_d = ui_in;
                        if (uio_in[LOAD_B]) b_d = ui_in;
                    end
                end
                ST_RUN: begin
                    sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                    sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                    res_d = {bit_d, res_q[WIDTH-2:1]};
                    bin_d = bit_bout;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        uo_d     = diff_full;
                        borrow_d = bit_bout;
`ifdef SUB_OVERFLOW_EN
                        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff_full[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            uo_q     <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            uo_q     <= uo_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

    assign uo_out  = uo_q;
    assign uio_out = {state_q == ST_RUN, state_q == ST_DONE, borrow_q, ovf_bit, 4'b0000};
    assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for the bit-serial subtractor: directed table, corner sequences, random ops.
module tb_tt_um_serial_subtractor;

`ifdef SUB_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int   u, s;
        u    = int'(a) - int'(b);
        s    = int'($signed(a)) - int'($signed(b));
        v.a  = a;
        v.b  = b;
        v.d  = u[7:0];
        v.br = (u < 0);
        v.ov = OVF_ON && (s > 127 || s < -128);
        return v;
    endfunction

    // mode: 0 normal, 1 ena stall of 3 cycles, 2 load/start injected in RUN, 3 reuse stored A
    task automatic do_op(input vec_t e, input int mode, input string nm);
        int cyc, busy_cnt, exp_cyc;
        if (mode != 3) begin
            uio_in = 8'h01; ui_in = e.a; tick;
        end
        uio_in = 8'h02; ui_in = e.b; tick;
        uio_in = 8'h04; ui_in = 8'h00; tick;
        uio_in = 8'h00;
        cyc = 0; busy_cnt = 0;
        while (!uio_out[6] && cyc < 30) begin
            if (uio_out[7]) busy_cnt++;
            if (mode == 1 && cyc == 2) ena = 1'b0;
            if (mode == 1 && cyc == 5) ena = 1'b1;
            if (mode == 2 && cyc == 3) begin ui_in = 8'hFF; uio_in = 8'h05; end
            else if (mode == 2) uio_in = 8'h00;
            tick;
            cyc++;
        end
        ena = 1'b1; uio_in = 8'h00;
        exp_cyc = (mode == 1) ? 11 : 8;
        check({nm, " latency"}, cyc, exp_cyc);
        check({nm, " busy cycles"}, busy_cnt, exp_cyc);
        check({nm, " diff"}, uo_out, e.d);
        check({nm, " borrow"}, uio_out[5], e.br);
        check({nm, " ovf"}, uio_out[4], e.ov);
        check({nm, " low bits"}, uio_out[3:0], 4'h0);
        tick;
        check({nm, " done 1 cycle"}, uio_out[7:6], 2'b00);
        tick;
        check({nm, " hold"}, {uo_out, uio_out[5:4]}, {e.d, e.br, e.ov});
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        tbl[0] = '{8'h50, 8'h20, 8'h30, 1'b0, 1'b0};
        tbl[1] = '{8'h20, 8'h50, 8'hD0, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, OVF_ON};
        tbl[3] = '{8'hAA, 8'h55, 8'h55, 1'b0, OVF_ON};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, OVF_ON};

        #2;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'hF0);
        tick;
        rst_n = 1'b1;
        tick;
        check("idle uio_out", uio_out, 8'h00);

        for (int i = 0; i < 8; i++) do_op(tbl[i], 0, $sformatf("tbl%0d", i));

        // Stall with ena low mid-run
        do_op(tbl[3], 1, "stall");

        // Loads and start pulsed during RUN must be ignored, A keeps 0x10
        v = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        do_op(v, 2, "inject");
        do_op(v, 3, "A kept");

        // Both loads together write the same byte to A and B
        uio_in = 8'h03; ui_in = 8'h3C; tick;
        uio_in = 8'h04; tick;
        uio_in = 8'h00;
        for (int i = 0; i < 8; i++) tick;
        check("both load done", uio_out[6], 1'b1);
        check("both load diff", uo_out, 8'h00);
        tick;

        // Reset asserted mid-run discards the operation
        uio_in = 8'h01; ui_in = 8'h33; tick;
        uio_in = 8'h02; ui_in = 8'h11; tick;
        uio_in = 8'h04; tick;
        uio_in = 8'h00;
        for (int i = 0; i < 4; i++) tick;
        check("pre-reset busy", uio_out[7], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset uo", uo_out, 8'h00);
        check("async reset uio", uio_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'hF0);
        tick;
        rst_n = 1'b1;
        tick;
        check("post-reset idle", uio_out, 8'h00);
        v = model(8'h00, 8'h07);
        do_op(v, 3, "A cleared");
        do_op(model(8'h05, 8'h03), 0, "after reset");

        for (int i = 0; i < 40; i++) begin
            v = model(8'($urandom), 8'($urandom));
            do_op(v, int'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tt_um_serial_subtractor.md
TT_UM_SERIAL_SUBTRACTOR -- requirements
Module: tt_um_serial_subtractor

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1, design enable; when 0, all registers hold.
REQ-004 SHALL have port ui_in, input, 8, operand data byte.
REQ-005 SHALL have port uio_in, input, 8: bit0 load_a, bit1 load_b, bit2 start; bits 7:3 unused.
REQ-006 SHALL have port uo_out, output, 8, registered difference a-b (mod 256).
REQ-007 SHALL have port uio_out, output, 8: bit7 busy, bit6 done, bit5 borrow, bit4 overflow; bits 3:0 tied 0.
REQ-008 SHALL have port uio_oe, output, 8, constant 8'hF0.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE.
REQ-010 IDLE with ena=1: load_a=1 writes ui_in to A reg; load_b=1 writes ui_in to B reg; both high writes the same byte to both.
REQ-011 IDLE, start=1: SHALL copy A and B into shift registers, clear bit counter and borrow-in, and enter RUN; loads on that same edge are ignored.
REQ-012 RUN: one bit per cycle, LSB first, through a 1-bit full subtractor; borrow registered between bits; 8 RUN cycles.
REQ-013 After the 8th RUN edge (counter 7): SHALL enter DONE, write the difference to uo_out and final borrow-out to borrow, and update overflow.
REQ-014 Latency: start sampled on edge E0 -> done=1 and uo_out valid after edge E8.
REQ-015 DONE SHALL last exactly one cycle (done=1), then return to IDLE unconditionally.
REQ-016 busy SHALL be 1 exactly while in RUN.
REQ-017 load_a, load_b and start SHALL be ignored in RUN and DONE.
REQ-018 uo_out, borrow and overflow SHALL hold their values until the next DONE entry.
REQ-019 Bit counter SHALL be 3 bits and wrap 7->0 on the RUN->DONE transition.
REQ-020 ena=0 in any state SHALL freeze state, counter, shift registers and outputs.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, A=B=0, shift registers=0, counter=0, uo_out=0, busy=done=borrow=overflow=0, including mid-RUN (in-flight operation discarded, no done pulse).
REQ-022 uio_oe SHALL read 8'hF0 during and after reset.

Configuration
REQ-023 With SUB_OVERFLOW_EN defined: overflow SHALL be set at DONE to signed two's-complement overflow of a-b (a[7]!=b[7] and result[7]!=a[7]).
REQ-024 Without SUB_OVERFLOW_EN: uio_out[4] SHALL be constant 0, and no overflow logic synthesized.

Structure
REQ-025 Package serial_sub_pkg SHALL hold the state enum, WIDTH=8, CNT_W=3, and uio bit-index constants (LOAD_A, LOAD_B, START, BUSY, DONE, BORROW, OVF).
REQ-026 Sub-module full_sub1 (inputs x, y, bin; outputs d, bout) SHALL be instantiated once for the serial datapath.

Verification
REQ-027 load_a 0x50, load_b 0x20, start -> after 8 cycles uo_out=0x30, borrow=0, done pulse 1 cycle.
REQ-028 A=0x20, B=0x50, start -> uo_out=0xD0, borrow=1; busy high for exactly 8 cycles.
REQ-029 A=0x80, B=0x01 -> uo_out=0x7F, borrow=0, overflow=1 with SUB_OVERFLOW_EN, 0 without.
REQ-030 During RUN of 0x10-0x01, pulse load_a=0xFF and start -> result still 0x0F; A reg still 0x10 afterward.
REQ-031 rst_n low at RUN cycle 4 -> all outputs 0, IDLE next; subsequent 0x05-0x03 yields 0x02.
REQ-032 ena=0 for 3 cycles mid-RUN of 0xAA-0x55 -> done delayed by 3 cycles, uo_out=0x55, borrow=0.
